// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone classic round-robin arbiter onto one shared slave port; grant registered, data path combinational.
// Optional BUSY watchdog enabled by defining WB_ARB_TIMEOUT_EN (error-terminates after TIMEOUT_CYCLES).
module wb_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        resetb,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;     // 0 = m0, 1 = m1
  logic       last_q, last_d;       // master that owned the last finished grant
  logic       m0_req, m1_req;
  logic       busy;
  logic       own_cyc, own_stb;
  logic       ack_ok;
  logic       tmo;

  assign m0_req  = m0_cyc_i & m0_stb_i;
  assign m1_req  = m1_cyc_i & m1_stb_i;
  assign busy    = (state_q == ST_BUSY);
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

  // An ack is only honoured while the owner still holds cyc; a dropped cyc is an abort.
  assign ack_ok  = busy & own_cyc & s_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tmo   = busy & own_cyc & ~s_ack_i & (cnt_q == TMO_LAST);
  assign cnt_d = busy ? (cnt_q + 8'd1) : 8'd0;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m0_err_o = tmo & resetb & ~owner_q;
  assign m1_err_o = tmo & resetb & owner_q;
`else
  assign tmo      = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  assign m0_ack_o = ack_ok & resetb & ~owner_q;
  assign m1_ack_o = ack_ok & resetb & owner_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = busy ? {owner_q, ~owner_q} : 2'b00;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    if (busy) begin
      s_cyc_o = own_cyc & ~tmo;
      s_stb_o = own_stb & ~tmo;
      s_we_o  = owner_q ? m1_we_i  : m0_we_i;
      s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
      s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
      s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          owner_d = ~last_q;
          state_d = ST_BUSY;
        end else if (m0_req) begin
          owner_d = 1'b0;
          state_d = ST_BUSY;
        end else if (m1_req) begin
          owner_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      default: begin
        if (!own_cyc || ack_ok || tmo) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, BUSY cycles without slave ack before error termination; range 2..255, 8-bit counter.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 resetb  in  1  synchronous, active-low reset.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (management SoC) Wishbone classic control.
REQ-005 m0_sel_i  in  4; m0_adr_i  in  32; m0_dat_i  in  32  master 0 byte select, address, write data.
REQ-006 m0_ack_o, m0_err_o  out  1 each; m0_dat_o  out  32  master 0 termination and read data.
REQ-007 m1_*  same set, widths and directions as m0_*  master 1 (internal test engine).
REQ-008 s_cyc_o, s_stb_o, s_we_o  out  1 each; s_sel_o  out  4; s_adr_o  out  32; s_dat_o  out  32  shared slave port.
REQ-009 s_ack_i  in  1; s_dat_i  in  32  slave termination and read data.
REQ-010 grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-011 FSM states: IDLE, BUSY; exactly one master owns the slave in BUSY.
REQ-012 Request = mX_cyc_i & mX_stb_i, sampled in IDLE.
REQ-013 IDLE, one request: grant it; BUSY next cycle.
REQ-014 IDLE, both requests: grant master not in last_grant; last_grant toggles only on completed or errored grant.
REQ-015 IDLE, no request: stay IDLE; s_cyc_o = s_stb_o = 0, grant_o = 00.
REQ-016 BUSY: s_cyc/stb/we/sel/adr/dat outputs combinationally mirror the granted master; non-granted master sees ack = err = 0.
REQ-017 Latency: request in IDLE at cycle N -> s_cyc_o = s_stb_o = 1 at N+1.
REQ-018 s_ack_i in BUSY: routed combinationally to granted master's ack the same cycle; IDLE next cycle; last_grant <= owner.
REQ-019 Earliest back-to-back grant: two cycles after ack (one IDLE cycle between transactions).
REQ-020 Granted master deasserts cyc in BUSY before ack: abort, IDLE next cycle, no ack/err delivered, last_grant <= owner.
REQ-021 s_ack_i while IDLE: ignored, no master ack.
REQ-022 m0_dat_o = m1_dat_o = s_dat_i at all times (qualified by ack).
REQ-023 Non-granted master request held pending; never dropped or acked until its grant.

Reset
REQ-024 resetb = 0 at rising edge: state IDLE, last_grant = m1 (m0 wins first tie), timeout counter 0, grant_o = 00, s_cyc_o = s_stb_o = 0, all acks/errs 0.
REQ-025 Reset mid-BUSY: transaction abandoned, no ack/err delivered, slave outputs low from next cycle.

Configuration
REQ-026 Macro WB_ARB_TIMEOUT_EN.
REQ-027 Defined: counter clears on BUSY entry, increments each BUSY cycle without ack; at TIMEOUT_CYCLES-1 asserts owner's err for one cycle, drops s_cyc_o/s_stb_o that cycle, IDLE next, last_grant <= owner.
REQ-028 Defined, ack and timeout in same cycle: ack wins, no err.
REQ-029 Undefined: no counter, mX_err_o tied 0, BUSY holds until ack or abort.

Verification
REQ-030 Reset, m0 read adr 0x3000_0000, slave acks 2 cycles after stb with 0xDEAD_BEEF -> m0_ack_o 1 cycle, m0_dat_o = 0xDEAD_BEEF, grant_o 01 -> 00.
REQ-031 m0 and m1 request same cycle, held for 4 transactions -> grant order m0, m1, m0, m1; one IDLE cycle between each.
REQ-032 m1 write 0x0000_4141 sel 0xF while m0 owns -> m1 waits, s_dat_o = 0x0000_4141 only when grant_o = 10.
REQ-033 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never acks -> owner err at 16th BUSY cycle, no ack, IDLE next.
REQ-034 m0 drops cyc 3 cycles into BUSY, m1 pending -> no m0 ack/err, m1 granted two cycles later.
REQ-035 resetb low during BUSY, slave acks same cycle -> no master ack, grant_o = 00, s_cyc_o = 0 next cycle.
